// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: transforms LANES bytes of a 128-bit state per cycle.
// GF(2^8) inversion is done in GF((2^4)^2): GF(16) = GF(2)[x]/(x^4+x+1), y^2 = y + x^3.
module inv_sub_bytes_seq #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int         STEPS = 16 / LANES;
  localparam logic [4:0] LAST  = 5'(STEPS - 1);

  // Column i = image of basis bit i. TO_COMP: AES polynomial basis -> composite
  // {ah, al}; TO_AES: composite -> AES (built from beta = 0xE1, gamma = 0xAE).
  localparam logic [63:0] TO_COMP = {8'hB5, 8'h5D, 8'hEB, 8'h51, 8'h34, 8'h3C, 8'h46, 8'h01};
  localparam logic [63:0] TO_AES  = {8'h89, 8'hBF, 8'hFA, 8'hAE, 8'h0C, 8'h5C, 8'hE1, 8'h01};
  localparam logic [3:0]  LAMBDA  = 4'h8;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] s;
    p = 4'h0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // a^14 = a^-1 in GF(16); 0 maps to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] map8(input logic [7:0] v, input logic [63:0] m);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] gf256_inv(input logic [7:0] a);
    logic [7:0] c;
    logic [3:0] ah;
    logic [3:0] al;
    logic [3:0] d;
    logic [3:0] di;
    c  = map8(a, TO_COMP);
    ah = c[7:4];
    al = c[3:0];
    d  = gf16_mul(gf16_mul(ah, ah), LAMBDA) ^ gf16_mul(ah, al) ^ gf16_mul(al, al);
    di = gf16_inv(d);
    return map8({gf16_mul(ah, di), gf16_mul(ah ^ al, di)}, TO_AES);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf256_inv(t);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     cnt_reg, cnt_next;
  logic [127:0]   work_reg, work_next;
  logic [4:0]     base;
  logic [7:0]     lane_out [LANES];

  assign base     = cnt_reg * 5'(LANES);
  assign out_data = work_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_out[gi] = inv_sbox(work_reg[{base + 5'(gi), 3'b000} +: 8]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      work_reg  <= 128'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      work_reg  <= work_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          work_next  = in_data;
          cnt_next   = 5'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < LANES; i++) begin
          work_next[{base + 5'(i), 3'b000} +: 8] = lane_out[i];
        end
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomised self-checking bench for inv_sub_bytes_seq (LANES=1 and LANES=16 instances)
// against an S-box model derived by brute-force GF(2^8) search.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = 128'd0;

  logic         iv1, iv16, or1, or16;
  logic         ir1, ir16, ov1, ov16, bz1, bz16;
  logic [127:0] od1, od16;
  logic         ir, ov, bz;
  logic [127:0] od;

  assign iv1  = in_valid & ~sel;
  assign iv16 = in_valid & sel;
  assign or1  = out_ready & ~sel;
  assign or16 = out_ready & sel;
  assign ir   = sel ? ir16 : ir1;
  assign ov   = sel ? ov16 : ov1;
  assign bz   = sel ? bz16 : bz1;
  assign od   = sel ? od16 : od1;

  inv_sub_bytes_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1)
  );

  inv_sub_bytes_seq #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(in_data),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .busy(bz16)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) begin
            iv = 8'(y);
            break;
          end
        end
      end
      fwd_tab[x] = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic s, input logic [127:0] d, output int lat, output logic [127:0] res);
    sel = s;
    in_data = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (ov !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    res = od;
    $display("txn lanes=%0d in=%h out=%h latency=%0d", s ? 16 : 1, d, res, lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = rand128();
    tick();
    tick();
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov1); end
    checks++; if (bz1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bz1); end
    checks++; if (od1 !== 128'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", od1); end
    checks++; if ({ir16, ov16, bz16} !== 3'b100 || od16 !== 128'd0) begin
      errors++; $display("FAIL reset_lanes16 got=%b%b%b/%h exp=100/0", ir16, ov16, bz16, od16);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (bz1 !== 1'b0 || od1 !== 128'd0) begin
      errors++; $display("FAIL reset_priority busy=%b data=%h exp=0/0", bz1, od1);
    end
  endtask

  task automatic test_all_63();
    int lat;
    logic [127:0] res;
    run_one(1'b0, {16{8'h63}}, lat, res);
    checks++; if (lat != 16) begin errors++; $display("FAIL all63_latency got=%0d exp=16", lat); end
    checks++; if (res !== 128'd0) begin errors++; $display("FAIL all63_data got=%h exp=0", res); end
    checks++; if (ir !== 1'b0 || bz !== 1'b1) begin errors++; $display("FAIL done_flags ready=%b busy=%b exp=0/1", ir, bz); end
    handshake();
    checks++; if (ov !== 1'b0 || ir !== 1'b1) begin errors++; $display("FAIL handoff out_valid=%b in_ready=%b exp=0/1", ov, ir); end
  endtask

  task automatic test_known_vector();
    logic [127:0] d;
    logic [127:0] e;
    int lat;
    logic [127:0] res;
    d = {{10{8'h63}}, 8'h52, 8'hED, 8'h16, 8'h00, 8'h7C, 8'h63};
    e = {{10{8'h00}}, 8'h48, 8'h53, 8'hFF, 8'h52, 8'h01, 8'h00};
    for (int s = 0; s < 2; s++) begin
      run_one(s[0], d, lat, res);
      checks++; if (res !== e) begin errors++; $display("FAIL known_vector lanes_sel=%0d got=%h exp=%h", s, res, e); end
      handshake();
    end
  endtask

  task automatic test_hold();
    logic [127:0] d;
    logic [127:0] e;
    int lat;
    logic [127:0] res;
    int stray;
    d = rand128();
    e = model(d);
    run_one(1'b0, d, lat, res);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = rand128();
      tick();
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, ov); end
      checks++; if (od !== e) begin errors++; $display("FAIL hold_data cyc=%0d got=%h exp=%h", c, od, e); end
      checks++; if (ir !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, ir); end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (ov !== 1'b0 || bz !== 1'b0) begin errors++; $display("FAIL hold_release out_valid=%b busy=%b exp=0/0", ov, bz); end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov === 1'b1 || bz === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL hold_no_queue got=%0d active cycles exp=0", stray); end
  endtask

  task automatic test_reset_mid_run();
    int stray;
    int lat;
    logic [127:0] d;
    logic [127:0] res;
    sel = 1'b0;
    in_data = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0) begin
      errors++; $display("FAIL midrun_reset ready=%b valid=%b busy=%b exp=1/0/0", ir, ov, bz);
    end
    checks++; if (od !== 128'd0) begin errors++; $display("FAIL midrun_reset_data got=%h exp=0", od); end
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ov === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrun_stale got=%0d valid cycles exp=0", stray); end
    d = rand128();
    run_one(1'b0, d, lat, res);
    checks++; if (res !== model(d)) begin errors++; $display("FAIL midrun_recover got=%h exp=%h", res, model(d)); end
    handshake();
  endtask

  task automatic test_random();
    logic [127:0] d;
    int lat;
    logic [127:0] res;
    for (int t = 0; t < 8; t++) begin
      d = rand128();
      run_one(t[0], d, lat, res);
      checks++; if (res !== model(d)) begin errors++; $display("FAIL random_data t=%0d got=%h exp=%h", t, res, model(d)); end
      checks++; if (lat != (t[0] ? 1 : 16)) begin errors++; $display("FAIL random_latency t=%0d got=%0d exp=%0d", t, lat, t[0] ? 1 : 16); end
      handshake();
    end
  endtask

  task automatic test_identity();
    logic [127:0] d;
    logic [127:0] e;
    int lat;
    logic [127:0] res;
    for (int s = 0; s < 2; s++) begin
      for (int blk = 0; blk < 16; blk++) begin
        for (int i = 0; i < 16; i++) begin
          d[8*i +: 8] = fwd_tab[blk*16 + i];
          e[8*i +: 8] = 8'(blk*16 + i);
        end
        run_one(s[0], d, lat, res);
        checks++; if (res !== e) begin errors++; $display("FAIL identity sel=%0d blk=%0d got=%h exp=%h", s, blk, res, e); end
        checks++; if (lat != (s == 1 ? 1 : 16)) begin errors++; $display("FAIL identity_latency sel=%0d blk=%0d got=%0d", s, blk, lat); end
        handshake();
      end
    end
  endtask

  task automatic test_back_to_back(input logic s, input int n);
    logic [127:0] exp_q [$];
    int results;
    int last_acc;
    int cyc;
    int gap;
    logic pre_acc;
    logic pre_out;
    logic [127:0] pre_od;
    logic [127:0] pre_in;
    logic [127:0] e;
    gap = s ? 3 : 18;
    results = 0;
    last_acc = -1;
    cyc = 0;
    sel = s;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = rand128();
    while (results < n && cyc < 2000) begin
      pre_acc = ir;
      pre_out = ov;
      pre_od = od;
      pre_in = in_data;
      tick();
      cyc++;
      if (pre_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_duplicate sel=%0d got=%h exp=none", s, pre_od);
        end else begin
          e = exp_q.pop_front();
          if (pre_od !== e) begin errors++; $display("FAIL b2b_data sel=%0d got=%h exp=%h", s, pre_od, e); end
        end
        $display("txn b2b lanes=%0d result=%h", s ? 16 : 1, pre_od);
        results++;
      end
      if (pre_acc) begin
        exp_q.push_back(model(pre_in));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != gap) begin errors++; $display("FAIL b2b_period sel=%0d got=%0d exp=%0d", s, cyc - last_acc, gap); end
        end
        last_acc = cyc;
        in_data = rand128();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (results != n) begin errors++; $display("FAIL b2b_count sel=%0d got=%0d exp=%0d", s, results, n); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_lost sel=%0d got=%0d pending exp=0", s, exp_q.size()); end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_all_63();
    test_known_vector();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_identity();
    test_back_to_back(1'b0, 5);
    test_back_to_back(1'b1, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
